uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_sync_fifo.sv | 62 ++++++
 rtl/uart_tx_fifo.sv | 152 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions (TX state encoding, frame constants) used by transmitter and receiver.
// The TX_PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP  = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_sync_fifo.sv
// Single-clock FIFO with push/pop/count. A push while full or a pop while empty is ignored.
module uart_tx_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    wr_d  = do_push ? wr_q + PTR_ONE : wr_q;
    rd_d  = do_pop  ? rd_q + PTR_ONE : rd_q;
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is not reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO; frames go out back-to-back while bytes are queued.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state     | meaning
// TX_IDLE   | line high, waiting for a queued byte
// TX_START  | start bit (low)
// TX_DATA   | 8 data bits, LSB first
// TX_PARITY | even parity of the data byte (UART_TX_PARITY_EN only)
// TX_STOP   | stop bit (high); pops the next byte on its last cycle
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [UART_DATA_BITS-1:0]   in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam logic [11:0] BIT_LAST  = 12'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  DATA_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_e                 state_q, state_d;
  logic [11:0]               cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] frame_q, frame_d;
  logic                      tx_q, tx_d;
  logic                      done_q, done_d;
  logic                      pop, fifo_empty, fifo_full, bit_end;
  logic [UART_DATA_BITS-1:0] fifo_head;

  uart_tx_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .push_i  (in_valid && in_ready),
    .data_i  (in_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign in_ready = !fifo_full;
  assign bit_end  = (cnt_q == BIT_LAST);
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = (state_q != TX_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 12'd1;
    bit_d   = bit_q;
    frame_d = frame_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = fifo_head;
          tx_d    = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          bit_d   = '0;
          tx_d    = frame_q[0];
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = ^frame_q;
            state_d = TX_PARITY;
`else
            tx_d    = 1'b1;
            state_d = TX_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = frame_q[bit_q + 3'd1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      TX_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (bit_end) begin
          done_d = 1'b1;
          // Chain straight into the next start bit so queued frames have no gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            frame_d = fifo_head;
            tx_d    = 1'b0;
            state_d = TX_START;
          end else begin
            tx_d    = 1'b1;
            state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a line monitor decodes frames and compares.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy, tx_done;
  logic [2:0] fifo_count;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_err = 0;
  int         n_chk = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];
  int         frames_done = 0;
  int         last_start = 0;
  int         last_end = 0;
  int         acc_cyc = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Ideal line waveform: each frame bit repeated CPB times, start bit first.
  function automatic logic [63:0] line_of(input logic [7:0] b);
    logic [63:0] l;
    logic        bv[12];
    l = '0;
    bv[0] = 1'b0;
    for (int i = 0; i < 8; i++) bv[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    bv[9] = ^b;
`endif
    bv[NBITS-1] = 1'b1;
    for (int k = 0; k < FLEN; k++) l[k] = bv[k / CPB];
    return l;
  endfunction

  // Line monitor: samples tx once per cycle on the falling edge.
  bit          in_frame = 0;
  int          idx = 0;
  logic [63:0] obs, expl;
  bit          done_early;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0;
    end else begin
      if (in_frame) begin
        if (idx < FLEN) begin
          obs[idx] = tx;
          if (tx_done) done_early = 1;
          idx++;
        end else begin
          check("frame_bits", obs, expl);
          check("tx_done_at_end", tx_done, 1'b1);
          check("tx_done_early", done_early, 1'b0);
          in_frame = 0;
          frames_done++;
          last_end = cyc;
        end
      end
      if (!in_frame && tx == 1'b0) begin
        check("frame_expected", exp_q.size() > 0, 1'b1);
        expl = (exp_q.size() > 0) ? line_of(exp_q.pop_front()) : '1;
        obs = '0;
        obs[0] = tx;
        idx = 1;
        done_early = 0;
        in_frame = 1;
        last_start = cyc;
        start_q.push_back(cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_data = 8'($urandom);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("push_timeout", t < 2000, 1'b1);
    exp_q.push_back(b);
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int t = 0;
    while (frames_done < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("frames_timeout", frames_done >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy || in_frame || exp_q.size() > 0) && t < 5000) begin
      @(negedge clk);
      in_data = 8'($urandom);
      t++;
    end
    check("idle_timeout", t < 5000, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int t = 0;
    while (cyc < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("cycle_wait_timeout", cyc == target, 1'b1);
  endtask

  initial begin
    int f0, s, n0;
    int a0, a4;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);

    // Single byte into idle block
    f0 = frames_done;
    push_byte(8'hA5);
    s = acc_cyc + 1;
    wait_frames(f0 + 1, FLEN + 20);
    check("single_start_cycle", last_start, s);
    check("single_frame_len", last_end - last_start, FLEN);
    check("single_busy_after", busy, 1'b0);
    wait_idle();

    // Five back-to-back bytes: queue fills, frames run contiguously
    f0 = frames_done;
    n0 = start_q.size();
    push_byte(8'h00); a0 = acc_cyc;
    push_byte(8'hFF);
    push_byte(8'h55);
    push_byte(8'h3C);
    push_byte(8'h81); a4 = acc_cyc;
    check("b2b_accepts", a4 - a0, 4);
    check("b2b_full_count", fifo_count, 3'd4);
    check("b2b_ready_low", in_ready, 1'b0);
    wait_frames(f0 + 5, 5 * FLEN + 50);
    for (int i = 1; i < 5; i++)
      check("b2b_contiguous", start_q[n0+i] - start_q[n0+i-1], FLEN);
    wait_idle();

    // Push on the same edge as a pop with three bytes queued
    f0 = frames_done;
    push_byte(8'h11);
    s = acc_cyc + 1;
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    check("pp_count_before", fifo_count, 3'd3);
    wait_cyc(s + FLEN - 1);
    in_data  = 8'h5E;
    in_valid = 1'b1;
    check("pp_ready", in_ready, 1'b1);
    exp_q.push_back(8'h5E);
    @(negedge clk);
    in_valid = 1'b0;
    check("pp_count_after", fifo_count, 3'd3);
    check("pp_done_pulse", tx_done, 1'b1);
    wait_frames(f0 + 5, 5 * FLEN + 50);
    wait_idle();

    // Randomized traffic; in_data is scrambled every idle cycle
    for (int i = 0; i < 16; i++) begin
      push_byte(8'($urandom));
      idle($urandom_range(0, 50));
    end
    wait_idle();
    check("random_all_sent", exp_q.size(), 0);

    // Reset during data bit 3 of 0x0F with two bytes queued
    push_byte(8'h0F);
    s = acc_cyc + 1;
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    check("rst_mid_count_before", fifo_count, 3'd2);
    wait_cyc(s + 4 * CPB + 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_tx", tx, 1'b1);
    check("rst_mid_count", fifo_count, 3'd0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_done", tx_done, 1'b0);
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", in_ready, 1'b1);
    f0 = frames_done;
    n0 = start_q.size();
    idle(3 * FLEN);
    check("rst_no_more_frames", start_q.size() - n0, 0);
    check("rst_no_done", frames_done - f0, 0);
    check("rst_line_high", tx, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
